// File: rtl/vx_rop_req_serializer.sv
// Fragment request serializer: buffers SIMD queue entries and emits one
// active lane per cycle, ascending lane order, FIFO entry order.
module vx_rop_req_serializer #(
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned DIM_BITS    = 12,
   parameter int unsigned DEPTH_BITS  = 24,
   parameter int unsigned QUEUE_SIZE  = 4,
   localparam int unsigned TID_BITS   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,

   input  logic                             req_valid,
   input  logic [NUM_THREADS-1:0]           req_tmask,
   input  logic [NUM_THREADS*DIM_BITS-1:0]  req_pos_x,
   input  logic [NUM_THREADS*DIM_BITS-1:0]  req_pos_y,
   input  logic [NUM_THREADS*32-1:0]        req_color,
   input  logic [NUM_THREADS*DEPTH_BITS-1:0] req_depth,
   input  logic [NUM_THREADS-1:0]           req_backface,
   output logic                             req_ready,

   output logic                             frag_valid,
   output logic [DIM_BITS-1:0]              frag_pos_x,
   output logic [DIM_BITS-1:0]              frag_pos_y,
   output logic [31:0]                      frag_color,
   output logic [DEPTH_BITS-1:0]            frag_depth,
   output logic                             frag_backface,
   output logic [TID_BITS-1:0]              frag_tid,
   output logic                             frag_last,
   input  logic                             frag_ready,

   output logic                             idle
);

   localparam int unsigned PTR_BITS = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
   localparam int unsigned CNT_BITS = PTR_BITS + 1;

   logic [NUM_THREADS-1:0]            tmask_q    [QUEUE_SIZE];
   logic [NUM_THREADS*DIM_BITS-1:0]   pos_x_q    [QUEUE_SIZE];
   logic [NUM_THREADS*DIM_BITS-1:0]   pos_y_q    [QUEUE_SIZE];
   logic [NUM_THREADS*32-1:0]         color_q    [QUEUE_SIZE];
   logic [NUM_THREADS*DEPTH_BITS-1:0] depth_q    [QUEUE_SIZE];
   logic [NUM_THREADS-1:0]            backface_q [QUEUE_SIZE];

   logic [PTR_BITS-1:0]    head, tail, head_next;
   logic [CNT_BITS-1:0]    count;
   logic [NUM_THREADS-1:0] rem;
   logic [NUM_THREADS-1:0] lane_bit;
   logic [TID_BITS-1:0]    tid;
   int unsigned            lane;
   logic                   full, push, fire, pop;

   assign full       = (count == CNT_BITS'(QUEUE_SIZE));
   assign req_ready  = !full;
   assign frag_valid = (count != '0);
   assign idle       = (count == '0);
   assign push       = req_valid && !full && (req_tmask != '0);
   assign fire       = frag_valid && frag_ready;
   assign pop        = fire && frag_last;
   assign head_next  = head + PTR_BITS'(1);
   assign frag_tid   = tid;
   assign frag_last  = (rem != '0) && ((rem & (rem - NUM_THREADS'(1))) == '0);

   // Pick the lowest-index lane still pending in the head entry
   always_comb begin
      tid      = '0;
      lane     = 0;
      lane_bit = '0;
      for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
         if (rem[i]) begin
            tid      = TID_BITS'(i);
            lane     = i;
            lane_bit = NUM_THREADS'(1) << i;
         end
      end
   end

   // Route the selected lane's fields of the head entry to the fragment port
   always_comb begin
      frag_pos_x    = pos_x_q[head][lane*DIM_BITS +: DIM_BITS];
      frag_pos_y    = pos_y_q[head][lane*DIM_BITS +: DIM_BITS];
      frag_color    = color_q[head][lane*32 +: 32];
      frag_depth    = depth_q[head][lane*DEPTH_BITS +: DEPTH_BITS];
      frag_backface = backface_q[head][lane];
   end

   // Entry storage, written at the tail on accepted non-empty entries
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         tmask_q[tail]    <= req_tmask;
         pos_x_q[tail]    <= req_pos_x;
         pos_y_q[tail]    <= req_pos_y;
         color_q[tail]    <= req_color;
         depth_q[tail]    <= req_depth;
         backface_q[tail] <= req_backface;
      end
   end

   // Queue pointers, occupancy and the head entry's remaining-lane mask
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         rem   <= '0;
      end else begin
         if (push) tail <= tail + PTR_BITS'(1);
         if (pop)  head <= head_next;

         case ({push, pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase

         // With one entry left, a concurrent push lands at head_next
         if (pop) begin
            if (count > CNT_BITS'(1)) rem <= tmask_q[head_next];
            else if (push)            rem <= req_tmask;
            else                      rem <= '0;
         end else if (fire) begin
            rem <= rem & ~lane_bit;
         end else if (count == '0 && push) begin
            rem <= req_tmask;
         end
      end
   end

endmodule
